// File: rtl/scan_doubler_pkg.sv
`default_nettype none
// ==================================================================
// scan_doubler_pkg - shared types and default sizes for the doubler
// Revision: 1.0
// ==================================================================
package scan_doubler_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS0 = 2'd1,
    PASS1 = 2'd2
  } state_e;

  localparam int DEF_BUF_DEPTH = 512;
  localparam int DEF_ADDR_W    = 9;

endpackage
`default_nettype wire

// File: rtl/scan_doubler_if.sv
`default_nettype none
// ==================================================================
// scan_doubler_if - pixel stream in, doubled video stream out
// Revision: 1.0
// ==================================================================
interface scan_doubler_if;

  logic pixel_ce;
  logic video_in;
  logic h_sync_in;
  logic v_sync_in;
  logic video_out;
  logic h_sync_out;
  logic v_sync_out;
  logic overflow;

  modport master (
    output pixel_ce, video_in, h_sync_in, v_sync_in,
    input  video_out, h_sync_out, v_sync_out, overflow
  );

  modport slave (
    input  pixel_ce, video_in, h_sync_in, v_sync_in,
    output video_out, h_sync_out, v_sync_out, overflow
  );

endinterface
`default_nettype wire

// File: rtl/scan_doubler_line_buffer.sv
`default_nettype none
// ==================================================================
// scan_doubler_line_buffer - 2-bank x BUF_DEPTH x 1 simple dual-port RAM
// Revision: 1.0
// ==================================================================
module scan_doubler_line_buffer
  import scan_doubler_pkg::*;
#(
  parameter int BUF_DEPTH = DEF_BUF_DEPTH,
  parameter int ADDR_W    = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic              wr_bank_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic              wr_data_i,
  input  logic              rd_bank_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              rd_data_o
);

  // No reset on the array or read register so the tools map it to block RAM.
  logic mem_q [2*BUF_DEPTH];
  logic rd_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[{wr_bank_i, wr_addr_i}] <= wr_data_i;
    end
    rd_q <= mem_q[{rd_bank_i, rd_addr_i}];
  end

  assign rd_data_o = rd_q;

endmodule
`default_nettype wire

// File: rtl/scan_doubler.sv
`default_nettype none
// ==================================================================
// scan_doubler - replays each input scanline twice at the doubled clock rate
// Revision: 1.0
// ==================================================================
module scan_doubler
  import scan_doubler_pkg::*;
#(
  parameter int BUF_DEPTH = DEF_BUF_DEPTH,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int HS_START  = 400,
  parameter int HS_WIDTH  = 48
) (
  input  logic         clk,
  input  logic         reset,
  scan_doubler_if.slave vid
);

  localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(BUF_DEPTH);
  localparam logic [ADDR_W:0] c_one   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] c_hs_lo = (ADDR_W+1)'(HS_START);
  localparam logic [ADDR_W:0] c_hs_hi = (ADDR_W+1)'(HS_START + HS_WIDTH);

  logic              hs_prev_q, edge_q, hs_rise;
  logic              bank_q, bank_d;
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   in_len_q, in_len_d;
  logic              line_valid_q, line_valid_d;
  logic              overflow_q, overflow_d;
  logic              v_sync_q, v_sync_d;
  logic              we, wr_bank;
  logic [ADDR_W-1:0] wr_addr;

  state_e            state_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic              rd_bank_q;
  logic              last_px, hs_win, ram_q;
  logic              active_q, hs_win_q, video_q, h_sync_q;

  assign hs_rise = vid.pixel_ce & vid.h_sync_in & ~hs_prev_q;

  always_comb begin
    bank_d       = bank_q;
    wr_ptr_d     = wr_ptr_q;
    in_len_d     = in_len_q;
    line_valid_d = line_valid_q;
    overflow_d   = overflow_q;
    v_sync_d     = v_sync_q;
    we           = 1'b0;
    wr_bank      = bank_q;
    wr_addr      = wr_ptr_q[ADDR_W-1:0];
    if (vid.pixel_ce) begin
      if (hs_rise) begin
        // New line: its first pixel lands at address 0 of the freshly selected bank.
        bank_d   = ~bank_q;
        in_len_d = wr_ptr_q;
        wr_ptr_d = c_one;
        we       = 1'b1;
        wr_bank  = ~bank_q;
        wr_addr  = '0;
        v_sync_d = vid.v_sync_in;
        if (wr_ptr_q != '0) begin
          line_valid_d = 1'b1;
        end
      end else if (wr_ptr_q < c_depth) begin
        we       = 1'b1;
        wr_ptr_d = wr_ptr_q + c_one;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_prev_q    <= 1'b0;
      edge_q       <= 1'b0;
      bank_q       <= 1'b0;
      wr_ptr_q     <= '0;
      in_len_q     <= '0;
      line_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      v_sync_q     <= 1'b0;
    end else begin
      if (vid.pixel_ce) begin
        hs_prev_q <= vid.h_sync_in;
      end
      edge_q       <= hs_rise;
      bank_q       <= bank_d;
      wr_ptr_q     <= wr_ptr_d;
      in_len_q     <= in_len_d;
      line_valid_q <= line_valid_d;
      overflow_q   <= overflow_d;
      v_sync_q     <= v_sync_d;
    end
  end

  assign last_px = ({1'b0, rd_ptr_q} == (in_len_q - c_one));

  // The read bank is latched at pass start so the final pixel of a pass,
  // presented in the same cycle the bank flips, still reads the old line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rd_ptr_q  <= '0;
      rd_bank_q <= 1'b0;
    end else if (edge_q) begin
      rd_ptr_q  <= '0;
      rd_bank_q <= ~bank_q;
      state_q   <= (line_valid_q && (in_len_q != '0)) ? PASS0 : IDLE;
    end else begin
      case (state_q)
        PASS0: begin
          if (last_px) begin
            state_q  <= PASS1;
            rd_ptr_q <= '0;
          end else begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
          end
        end
        PASS1: begin
          if (last_px) begin
            state_q  <= IDLE;
            rd_ptr_q <= '0;
          end else begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
          end
        end
        default: begin
          state_q  <= IDLE;
          rd_ptr_q <= '0;
        end
      endcase
    end
  end

  scan_doubler_line_buffer #(
    .BUF_DEPTH (BUF_DEPTH),
    .ADDR_W    (ADDR_W)
  ) u_line_buffer (
    .clk       (clk),
    .we_i      (we),
    .wr_bank_i (wr_bank),
    .wr_addr_i (wr_addr),
    .wr_data_i (vid.video_in),
    .rd_bank_i (rd_bank_q),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (ram_q)
  );

  assign hs_win = (state_q != IDLE) &&
                  ({1'b0, rd_ptr_q} >= c_hs_lo) &&
                  ({1'b0, rd_ptr_q} <  c_hs_hi);

  // Two stages (RAM read, output register) keep sync aligned with pixel data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q <= 1'b0;
      hs_win_q <= 1'b0;
      video_q  <= 1'b0;
      h_sync_q <= 1'b0;
    end else begin
      active_q <= (state_q != IDLE);
      hs_win_q <= hs_win;
      video_q  <= active_q & ram_q;
      h_sync_q <= hs_win_q;
    end
  end

  assign vid.video_out  = video_q;
  assign vid.h_sync_out = h_sync_q;
  assign vid.v_sync_out = v_sync_q;
  assign vid.overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_scan_doubler.sv
`default_nettype none
// ==================================================================
// tb_scan_doubler - directed scoreboard bench for scan_doubler
// Revision: 1.0
// ==================================================================
module tb_scan_doubler;

  typedef struct {
    int cyc;
    bit v;
    bit h;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  scan_doubler_if vid ();

  scan_doubler #(
    .BUF_DEPTH (512),
    .ADDR_W    (9),
    .HS_START  (400),
    .HS_WIDTH  (48)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .vid   (vid)
  );

  exp_t sb[$];
  int   cyc;
  int   checks;
  int   errors;
  int   cur_len;
  bit   hs_prev_tb;
  bit   exp_vs;
  bit   exp_ovf;
  bit   cur_line [512];

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0b expected=%0b", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_outputs();
    exp_t e;
    bit   ev;
    bit   eh;
    ev = 1'b0;
    eh = 1'b0;
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e  = sb.pop_front();
      ev = e.v;
      eh = e.h;
    end
    chk("video_out",  vid.video_out,  ev);
    chk("h_sync_out", vid.h_sync_out, eh);
    chk("v_sync_out", vid.v_sync_out, exp_vs);
    chk("overflow",   vid.overflow,   exp_ovf);
  endtask

  task automatic idle_cycle();
    vid.pixel_ce = 1'b0;
    @(posedge clk);
    cyc++;
    #1 check_outputs();
  endtask

  // One input pixel = a pixel_ce cycle followed by a quiet cycle.
  task automatic send_pixel(input bit v, input bit hs, input bit vs);
    exp_t e;
    vid.pixel_ce  = 1'b1;
    vid.video_in  = v;
    vid.h_sync_in = hs;
    vid.v_sync_in = vs;
    @(posedge clk);
    cyc++;
    if (hs && !hs_prev_tb) begin
      // A new line cuts off whatever replay is still scheduled 3+ cycles out.
      while (sb.size() > 0 && sb[$].cyc >= cyc + 3) void'(sb.pop_back());
      for (int p = 0; p < 2; p++) begin
        for (int j = 0; j < cur_len; j++) begin
          e.cyc = cyc + 3 + p * cur_len + j;
          e.v   = cur_line[j];
          e.h   = (j >= 400) && (j < 448);
          sb.push_back(e);
        end
      end
      exp_vs      = vs;
      cur_line[0] = v;
      cur_len     = 1;
    end else if (cur_len < 512) begin
      cur_line[cur_len] = v;
      cur_len++;
    end else begin
      exp_ovf = 1'b1;
    end
    hs_prev_tb = hs;
    #1 check_outputs();
    vid.pixel_ce = 1'b0;
    @(posedge clk);
    cyc++;
    #1 check_outputs();
  endtask

  // kind 0: 0xAA byte pattern (MSB first), kind 1: random pixels.
  task automatic send_line(input int n, input int kind, input bit vs_a, input bit vs_b);
    bit v;
    for (int i = 0; i < n; i++) begin
      if (kind == 0) v = (i % 2 == 0);
      else           v = 1'($urandom_range(0, 1));
      send_pixel(v, (i < 8), (i < n / 2) ? vs_a : vs_b);
    end
  endtask

  task automatic clear_model();
    sb.delete();
    hs_prev_tb = 1'b0;
    cur_len    = 0;
    exp_vs     = 1'b0;
    exp_ovf    = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d observed=running expected=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    clear_model();
    reset         = 1'b1;
    vid.pixel_ce  = 1'b0;
    vid.video_in  = 1'b0;
    vid.h_sync_in = 1'b0;
    vid.v_sync_in = 1'b0;
    repeat (2) idle_cycle();
    reset = 1'b0;

    send_line(512, 0, 1'b0, 1'b0);   // first line after reset replays blank
    send_line(512, 1, 1'b0, 1'b0);   // 0xAA line replayed twice with hsync
    send_line(512, 0, 1'b0, 1'b0);   // random line replayed
    send_line(300, 0, 1'b0, 1'b0);   // cuts the 512-pixel replay short
    send_line(600, 1, 1'b0, 1'b0);   // 300-pixel replay then idle; overflows
    send_line(512, 0, 1'b0, 1'b1);   // clamped 512 replay; v_sync_in rises mid-line
    send_line(512, 1, 1'b1, 1'b0);   // v_sync_out follows at this edge
    send_line(400, 0, 1'b1, 1'b1);   // stops inside PASS1 of the previous line

    #2 reset = 1'b1;
    clear_model();
    #1 check_outputs();
    repeat (2) idle_cycle();
    reset = 1'b0;

    send_line(512, 1, 1'b0, 1'b0);   // blank again after reset
    send_line(512, 0, 1'b0, 1'b0);   // random line from after reset replayed
    send_line(64, 1, 1'b0, 1'b0);
    repeat (8) idle_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
